// File: rtl/latch_sr_driver_pkg.sv
// Shared constants for the latch_sr front-end: FSM encodings and default timing.
package latch_sr_driver_pkg;

  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  localparam int unsigned DEB_CYCLES_DEF = 4;
  localparam int unsigned CNT_W_DEF      = 8;

endpackage

// File: rtl/latch_sr_driver_btn_conditioner.sv
// Pushbutton conditioner: 2-FF synchronizer, debounce counter, press pulse on accepted 1->0.
module latch_sr_driver_btn_conditioner
  import latch_sr_driver_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // Two-stage synchronizer; idle (released) level is 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level after DEB_CYCLES consecutive differing samples; pulse on press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync2;
          cnt   <= '0;
          press <= ~sync2;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/latch_sr_driver.sv
// Front-end for latch_sr: conditions start/stop/door, runs the S/R pulse FSM.
// latch_sr has no reset of its own, so the INIT state forces one R pulse after every reset.
module latch_sr_driver
  import latch_sr_driver_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic startn,
  input  logic stopn,
  input  logic door_closed,
  input  logic timer_done,
  output logic S,
  output logic R,
  output logic mag_on
);

  logic       start_press;
  logic       stop_press;
  logic       door_s1;
  logic       door_s2;
  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       s_nxt;
  logic       r_nxt;

  latch_sr_driver_btn_conditioner #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_start (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (startn),
    .press (start_press)
  );

  latch_sr_driver_btn_conditioner #(
    .DEB_CYCLES (DEB_CYCLES),
    .CNT_W      (CNT_W)
  ) u_stop (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (stopn),
    .press (stop_press)
  );

  // Door switch synchronizer; resets to "open" so nothing can start before it settles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      door_s1 <= 1'b0;
      door_s2 <= 1'b0;
    end else begin
      door_s1 <= door_closed;
      door_s2 <= door_s1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_INIT;
    else        state <= state_nxt;
  end

  // Next state and pulse requests; stop/timer outrank start and door-open.
  always_comb begin
    state_nxt = state;
    s_nxt     = 1'b0;
    r_nxt     = 1'b0;
    case (state)
      ST_INIT: begin
        state_nxt = ST_IDLE;
        r_nxt     = 1'b1;
      end
      ST_IDLE: begin
        if (start_press && !stop_press && door_s2 && !timer_done) begin
          state_nxt = ST_RUN;
          s_nxt     = 1'b1;
        end
      end
      ST_RUN: begin
        if (stop_press || timer_done) begin
          state_nxt = ST_IDLE;
          r_nxt     = 1'b1;
        end else if (!door_s2) begin
          state_nxt = ST_HOLD;
          r_nxt     = 1'b1;
        end
      end
      ST_HOLD: begin
        if (stop_press || timer_done) begin
          state_nxt = ST_IDLE;
        end else if (start_press && door_s2) begin
          state_nxt = ST_RUN;
          s_nxt     = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  // Registered outputs, updated on the transition edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S      <= 1'b0;
      R      <= 1'b0;
      mag_on <= 1'b0;
    end else begin
      S      <= s_nxt;
      R      <= r_nxt;
      mag_on <= (state_nxt == ST_RUN);
    end
  end

endmodule

// File: tb/tb_latch_sr_driver.sv
// Scoreboard bench for latch_sr_driver: a reference model predicts S/R pulses and mag_on,
// a monitor compares whatever the DUT presents against the queued predictions.
module tb_latch_sr_driver;

  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic startn = 1'b1;
  logic stopn = 1'b1;
  logic door_closed = 1'b0;
  logic timer_done = 1'b0;
  logic S, R, mag_on;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct { int cyc; bit s; bit r; } ev_t;
  ev_t sb[$];

  typedef enum { M_INIT, M_IDLE, M_RUN, M_HOLD } mstate_t;
  mstate_t m_state = M_INIT;
  logic hs[0:DEB+1];
  logic hp[0:DEB+1];
  logic hd[0:DEB+1];
  logic lvl_s = 1'b1, lvl_p = 1'b1;
  bit press_s = 0, press_p = 0;
  bit exp_mag = 0;

  latch_sr_driver #(.DEB_CYCLES(DEB), .CNT_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .startn      (startn),
    .stopn       (stopn),
    .door_closed (door_closed),
    .timer_done  (timer_done),
    .S           (S),
    .R           (R),
    .mag_on      (mag_on)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a button level is accepted once DEB consecutive synchronized
  // samples disagree with it; synchronized values lag raw samples by two edges.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= DEB + 1; i++) begin
        hs[i] = 1'b1; hp[i] = 1'b1; hd[i] = 1'b0;
      end
      lvl_s = 1'b1; lvl_p = 1'b1;
      press_s = 0; press_p = 0;
      m_state = M_INIT;
      exp_mag = 0;
      sb.delete();
    end else begin
      bit use_s, use_p, door, td, flip_s, flip_p, ps, pr;
      cyc++;
      for (int i = DEB + 1; i > 0; i--) begin
        hs[i] = hs[i-1]; hp[i] = hp[i-1]; hd[i] = hd[i-1];
      end
      hs[0] = startn; hp[0] = stopn; hd[0] = door_closed;
      use_s = press_s;
      use_p = press_p;
      door  = hd[2];
      td    = timer_done;
      flip_s = 1; flip_p = 1;
      for (int i = 2; i <= DEB + 1; i++) begin
        if (hs[i] == lvl_s) flip_s = 0;
        if (hp[i] == lvl_p) flip_p = 0;
      end
      press_s = flip_s && lvl_s;
      press_p = flip_p && lvl_p;
      if (flip_s) lvl_s = ~lvl_s;
      if (flip_p) lvl_p = ~lvl_p;
      ps = 0; pr = 0;
      if (m_state == M_INIT) begin
        m_state = M_IDLE; pr = 1;
      end else if (m_state == M_IDLE) begin
        if (use_s && !use_p && door && !td) begin m_state = M_RUN; ps = 1; end
      end else if (m_state == M_RUN) begin
        if (use_p || td) begin m_state = M_IDLE; pr = 1; end
        else if (!door) begin m_state = M_HOLD; pr = 1; end
      end else begin
        if (use_p || td) m_state = M_IDLE;
        else if (use_s && door) begin m_state = M_RUN; ps = 1; end
      end
      exp_mag = (m_state == M_RUN);
      if (ps || pr) sb.push_back('{cyc: cyc, s: ps, r: pr});
    end
  end

  // Monitor: consume a prediction whenever the DUT shows a pulse; track mag_on every cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missing_pulse expected S=%0d R=%0d at cycle %0d was not observed", sb[0].s, sb[0].r, sb[0].cyc);
        void'(sb.pop_front());
      end
      if (S || R) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse actual S=%0d R=%0d at cycle %0d, expected none", S, R, cyc);
        end else begin
          ev_t e;
          e = sb.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_S", int'(S), int'(e.s));
          check("pulse_R", int'(R), int'(e.r));
        end
      end
      check("mag_on", int'(mag_on), int'(exp_mag));
      if (S && R) check("s_and_r", 1, 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_start(input int n);
    startn = 1'b0; idle(n); startn = 1'b1; idle(8);
  endtask

  task automatic press_stop(input int n);
    stopn = 1'b0; idle(n); stopn = 1'b1; idle(8);
  endtask

  initial begin
    int sh, ph, th;
    // 1: reset and forced R pulse on release
    idle(2);
    check("rst_S", int'(S), 0);
    check("rst_R", int'(R), 0);
    check("rst_mag", int'(mag_on), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("init_R", int'(R), 1);
    check("init_S", int'(S), 0);
    @(negedge clk);
    check("init_R_off", int'(R), 0);
    idle(4);

    // 2: start with door closed, exact latency
    door_closed = 1'b1; idle(4);
    startn = 1'b0;
    idle(6);
    check("t2_S_early", int'(S), 0);
    @(negedge clk);
    check("t2_S_latency", int'(S), 1);
    @(negedge clk);
    check("t2_S_single", int'(S), 0);
    check("t2_mag", int'(mag_on), 1);
    idle(1); startn = 1'b1; idle(10);

    // back to IDLE, then 3: bouncy start yields nothing
    press_stop(6);
    check("t3_pre_mag", int'(mag_on), 0);
    for (int i = 0; i < 6; i++) begin
      startn = 1'b0; idle(2); startn = 1'b1; idle(2);
    end
    idle(10);
    check("t3_mag", int'(mag_on), 0);

    // 4: door open in RUN -> HOLD; start with door open ignored; close + start resumes
    press_start(6);
    check("t4_run", int'(mag_on), 1);
    door_closed = 1'b0; idle(6);
    check("t4_hold_mag", int'(mag_on), 0);
    press_start(6);
    check("t4_open_start", int'(mag_on), 0);
    door_closed = 1'b1; idle(4);
    press_start(6);
    check("t4_resume", int'(mag_on), 1);

    // 5: timer_done and door open together -> single R; start blocked while timer_done
    timer_done = 1'b1; door_closed = 1'b0;
    idle(4);
    check("t5_mag", int'(mag_on), 0);
    door_closed = 1'b1; idle(4);
    press_start(6);
    check("t5_blocked", int'(mag_on), 0);
    timer_done = 1'b0; idle(4);

    // 6: asynchronous reset in RUN
    press_start(6);
    check("t6_run", int'(mag_on), 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_S", int'(S), 0);
    check("t6_R", int'(R), 0);
    check("t6_mag", int'(mag_on), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("t6_R_pulse", int'(R), 1);
    idle(6);

    // Random phase: bouncy buttons with random hold lengths, occasional door/timer events.
    sh = 1; ph = 1; th = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (--sh <= 0) begin startn = 1'($urandom_range(0, 1)); sh = $urandom_range(1, 9); end
      if (--ph <= 0) begin stopn = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1; ph = $urandom_range(1, 9); end
      if ($urandom_range(0, 39) == 0) door_closed = ~door_closed;
      if (th > 0) th--;
      else if ($urandom_range(0, 59) == 0) th = $urandom_range(1, 3);
      timer_done = (th > 0);
    end
    startn = 1'b1; stopn = 1'b1; timer_done = 1'b0;
    idle(20);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
